echo_detector: RTL and testbench

ECHO_DETECTOR -- requirements
Module: echo_detector

---
 rtl/echo_detector_if.sv | 24 ++
 rtl/echo_detector.sv | 115 +++++++++++
 tb/tb_echo_detector.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/echo_detector_if.sv
// Bus between the ultrasonic front-end controller and the echo detector:
// emission/sample inputs plus the registered measurement outputs.
`timescale 1ns/1ps
interface echo_detector_if #(
  parameter int SAMPLE_WIDTH = 12
);
  logic                    emit_start_in;
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid_in;
  logic [SAMPLE_WIDTH-2:0] threshold_in;
  logic [31:0]             time_since_emission;
  logic                    echo_detected;
  logic                    listening_out;

  modport master (
    output emit_start_in, sample_in, sample_valid_in, threshold_in,
    input  time_since_emission, echo_detected, listening_out
  );

  modport slave (
    input  emit_start_in, sample_in, sample_valid_in, threshold_in,
    output time_since_emission, echo_detected, listening_out
  );
endinterface

// File: rtl/echo_detector.sv
// Time-of-flight echo detector: blanks after emission, then confirms an echo
// after CONFIRM_COUNT consecutive above-threshold rectified samples.
`timescale 1ns/1ps
module echo_detector #(
  parameter int SAMPLE_WIDTH    = 12,
  parameter int BLANKING_CYCLES = 20000,
  parameter int MAX_TIME_WINDOW = 500000,
  parameter int CONFIRM_COUNT   = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  echo_detector_if.slave bus
);

  localparam int AMP_W = SAMPLE_WIDTH - 1;
  localparam int RUN_W = $clog2(CONFIRM_COUNT + 1);
  localparam logic [31:0]      BLANK_END = 32'(BLANKING_CYCLES);
  localparam logic [31:0]      MAX_T     = 32'(MAX_TIME_WINDOW);
  localparam logic [RUN_W-1:0] CONFIRM_N = RUN_W'(CONFIRM_COUNT);

  typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} state_t;

  state_t           state;
  logic [31:0]      tse;
  logic [RUN_W-1:0] run_cnt;
  logic             echo_r;
  logic             listening_r;

  logic signed [SAMPLE_WIDTH:0] centred;
  logic [AMP_W-1:0]             amp;
  logic [31:0]                  tse_inc;
  logic [RUN_W-1:0]             run_inc;
  logic                         above;
  logic                         confirm;
  logic                         timeout;

  // Offset-binary to two's complement around mid-scale, one guard bit wide.
  function automatic logic signed [SAMPLE_WIDTH:0] centre(input logic [SAMPLE_WIDTH-1:0] s);
    return $signed({1'b0, s}) - $signed({2'b01, {(SAMPLE_WIDTH-1){1'b0}}});
  endfunction

  // Magnitude clamped to AMP_W bits; only the full-negative code overflows.
  function automatic logic [AMP_W-1:0] rectify_sat(input logic signed [SAMPLE_WIDTH:0] d);
    logic signed [SAMPLE_WIDTH:0] mag;
    mag = d[SAMPLE_WIDTH] ? -d : d;
    if (mag > $signed({2'b00, {AMP_W{1'b1}}}))
      return {AMP_W{1'b1}};
    return mag[AMP_W-1:0];
  endfunction

  always_comb begin
    centred = centre(bus.sample_in);
    amp     = rectify_sat(centred);
    above   = (amp >= bus.threshold_in);
    tse_inc = tse + 32'd1;
    run_inc = run_cnt + RUN_W'(1);
    confirm = bus.sample_valid_in && above && (run_inc == CONFIRM_N);
    timeout = (tse_inc == MAX_T);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      tse         <= '0;
      run_cnt     <= '0;
      echo_r      <= 1'b0;
      listening_r <= 1'b0;
    end else begin
      echo_r <= 1'b0;
      // A new emission restarts the measurement from any state and wins over
      // a coincident confirmation or timeout.
      if (bus.emit_start_in) begin
        state       <= BLANK;
        tse         <= '0;
        run_cnt     <= '0;
        listening_r <= 1'b1;
      end else begin
        case (state)
          BLANK: begin
            tse <= tse_inc;
            if (timeout) begin
              state       <= IDLE;
              listening_r <= 1'b0;
            end else if (tse_inc == BLANK_END) begin
              state   <= LISTEN;
              run_cnt <= '0;
            end
          end
          LISTEN: begin
            tse <= tse_inc;
            // Confirmation takes priority over timeout on the same edge.
            if (confirm) begin
              state       <= DONE;
              echo_r      <= 1'b1;
              listening_r <= 1'b0;
              run_cnt     <= '0;
            end else if (timeout) begin
              state       <= IDLE;
              listening_r <= 1'b0;
            end else if (bus.sample_valid_in) begin
              run_cnt <= above ? run_inc : '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.time_since_emission = tse;
  assign bus.echo_detected       = echo_r;
  assign bus.listening_out       = listening_r;

endmodule

// File: tb/tb_echo_detector.sv
// Scenario bench for echo_detector with shortened timing parameters; expected
// echo timestamps are queued by each scenario and matched when pulses appear.
`timescale 1ns/1ps
module tb_echo_detector;

  localparam int SW    = 12;
  localparam int BLANK = 20;
  localparam int MAXW  = 200;
  localparam int CONF  = 4;

  localparam logic [SW-1:0] S_BIG = 12'd4000;  // amplitude 1952
  localparam logic [SW-1:0] S_600 = 12'd2648;  // amplitude 600, above mid
  localparam logic [SW-1:0] S_400 = 12'd1648;  // amplitude 400, below mid

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  echo_detector_if #(.SAMPLE_WIDTH(SW)) bus ();

  echo_detector #(
    .SAMPLE_WIDTH   (SW),
    .BLANKING_CYCLES(BLANK),
    .MAX_TIME_WINDOW(MAXW),
    .CONFIRM_COUNT  (CONF)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int exp_tse;

  // Every echo pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (bus.echo_detected === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL echo_unexpected: pulse at tse=%0d, expected no pulse", bus.time_since_emission);
      end else begin
        exp_tse = exp_q.pop_front();
        if (bus.time_since_emission !== 32'(exp_tse)) begin
          fails++;
          $display("FAIL echo_tse: got %0d, expected %0d", bus.time_since_emission, exp_tse);
        end
      end
    end
  end

  task automatic drive(input logic e, input logic [SW-1:0] s, input logic v);
    bus.emit_start_in   = e;
    bus.sample_in       = s;
    bus.sample_valid_in = v;
    @(negedge clk_in);
    bus.emit_start_in   = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    bus.threshold_in = 11'd500;
    drive(1'b1, S_BIG, 1'b1);
    drive(1'b1, S_BIG, 1'b1);
    tests++; if (bus.time_since_emission !== 32'd0) begin fails++; $display("FAIL reset_tse: got %0d, expected 0", bus.time_since_emission); end
    tests++; if (bus.echo_detected !== 1'b0) begin fails++; $display("FAIL reset_echo: got %b, expected 0", bus.echo_detected); end
    tests++; if (bus.listening_out !== 1'b0) begin fails++; $display("FAIL reset_listen: got %b, expected 0", bus.listening_out); end
    rst_in = 1'b1;
    drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.listening_out !== 1'b0 || bus.time_since_emission !== 32'd0) begin fails++; $display("FAIL idle_hold: got listen=%b tse=%0d, expected 0/0", bus.listening_out, bus.time_since_emission); end
  endtask

  task automatic test_basic();
    bus.threshold_in = 11'd500;
    drive(1'b1, S_BIG, 1'b0);
    tests++; if (bus.time_since_emission !== 32'd0 || bus.listening_out !== 1'b1) begin fails++; $display("FAIL basic_emit: got tse=%0d listen=%b, expected 0/1", bus.time_since_emission, bus.listening_out); end
    exp_q.push_back(BLANK + CONF);
    repeat (BLANK) drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.time_since_emission !== 32'(BLANK) || bus.listening_out !== 1'b1) begin fails++; $display("FAIL basic_blank_end: got tse=%0d listen=%b, expected %0d/1", bus.time_since_emission, bus.listening_out, BLANK); end
    repeat (CONF) drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.echo_detected !== 1'b1 || bus.listening_out !== 1'b0) begin fails++; $display("FAIL basic_echo: got echo=%b listen=%b, expected 1/0", bus.echo_detected, bus.listening_out); end
    drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.echo_detected !== 1'b0 || bus.time_since_emission !== 32'(BLANK + CONF)) begin fails++; $display("FAIL basic_done_hold: got echo=%b tse=%0d, expected 0/%0d", bus.echo_detected, bus.time_since_emission, BLANK + CONF); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL basic_missed: got %0d pending echoes, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_timeout();
    bus.threshold_in = 11'd500;
    drive(1'b1, S_600, 1'b0);
    for (int i = 1; i < MAXW; i++) drive(1'b0, (i % 2) ? S_600 : S_400, 1'b1);
    tests++; if (bus.time_since_emission !== 32'(MAXW - 1) || bus.listening_out !== 1'b1) begin fails++; $display("FAIL tmo_before: got tse=%0d listen=%b, expected %0d/1", bus.time_since_emission, bus.listening_out, MAXW - 1); end
    drive(1'b0, S_600, 1'b1);
    tests++; if (bus.time_since_emission !== 32'(MAXW) || bus.listening_out !== 1'b0) begin fails++; $display("FAIL tmo_edge: got tse=%0d listen=%b, expected %0d/0", bus.time_since_emission, bus.listening_out, MAXW); end
    repeat (6) drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.time_since_emission !== 32'(MAXW) || bus.listening_out !== 1'b0) begin fails++; $display("FAIL tmo_idle_hold: got tse=%0d listen=%b, expected %0d/0", bus.time_since_emission, bus.listening_out, MAXW); end
    // emission coincident with timeout restarts the measurement
    drive(1'b1, S_BIG, 1'b0);
    repeat (MAXW - 1) drive(1'b0, S_BIG, 1'b0);
    drive(1'b1, S_BIG, 1'b1);
    tests++; if (bus.time_since_emission !== 32'd0 || bus.listening_out !== 1'b1) begin fails++; $display("FAIL tmo_vs_emit: got tse=%0d listen=%b, expected 0/1", bus.time_since_emission, bus.listening_out); end
    // fourth sample lands on the timeout edge: confirmation wins
    repeat (MAXW - CONF) drive(1'b0, S_BIG, 1'b0);
    exp_q.push_back(MAXW);
    repeat (CONF) drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.echo_detected !== 1'b1 || bus.time_since_emission !== 32'(MAXW)) begin fails++; $display("FAIL tmo_vs_confirm: got echo=%b tse=%0d, expected 1/%0d", bus.echo_detected, bus.time_since_emission, MAXW); end
    drive(1'b0, S_BIG, 1'b1);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL tmo_missed: got %0d pending echoes, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_gap();
    bus.threshold_in = 11'd500;
    drive(1'b1, S_BIG, 1'b0);
    repeat (BLANK) drive(1'b0, S_BIG, 1'b0);
    exp_q.push_back(BLANK + 5);
    repeat (3) drive(1'b0, S_BIG, 1'b1);
    drive(1'b0, S_BIG, 1'b0);
    drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.echo_detected !== 1'b1) begin fails++; $display("FAIL gap_invalid_echo: got %b, expected 1", bus.echo_detected); end
    drive(1'b1, S_BIG, 1'b0);
    repeat (BLANK) drive(1'b0, S_BIG, 1'b0);
    repeat (3) drive(1'b0, S_BIG, 1'b1);
    drive(1'b0, S_400, 1'b1);
    repeat (3) drive(1'b0, S_600, 1'b1);
    tests++; if (bus.echo_detected !== 1'b0 || bus.listening_out !== 1'b1 || bus.time_since_emission !== 32'(BLANK + 7)) begin fails++; $display("FAIL gap_below_reset: got echo=%b listen=%b tse=%0d, expected 0/1/%0d", bus.echo_detected, bus.listening_out, bus.time_since_emission, BLANK + 7); end
    exp_q.push_back(BLANK + 8);
    drive(1'b0, S_600, 1'b1);
    tests++; if (bus.echo_detected !== 1'b1) begin fails++; $display("FAIL gap_fourth_echo: got %b, expected 1", bus.echo_detected); end
    drive(1'b0, S_BIG, 1'b0);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL gap_missed: got %0d pending echoes, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bus.threshold_in = 11'd500;
    drive(1'b1, S_BIG, 1'b0);
    repeat (BLANK) drive(1'b0, S_BIG, 1'b0);
    repeat (3) drive(1'b0, S_BIG, 1'b1);
    // re-emission on the edge that would have confirmed
    drive(1'b1, S_BIG, 1'b1);
    tests++; if (bus.time_since_emission !== 32'd0 || bus.listening_out !== 1'b1 || bus.echo_detected !== 1'b0) begin fails++; $display("FAIL reemit: got tse=%0d listen=%b echo=%b, expected 0/1/0", bus.time_since_emission, bus.listening_out, bus.echo_detected); end
    repeat (BLANK + 3) drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.time_since_emission !== 32'(BLANK + 3) || bus.echo_detected !== 1'b0) begin fails++; $display("FAIL reemit_run_cleared: got tse=%0d echo=%b, expected %0d/0", bus.time_since_emission, bus.echo_detected, BLANK + 3); end
    exp_q.push_back(BLANK + CONF);
    drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.echo_detected !== 1'b1) begin fails++; $display("FAIL reemit_echo: got %b, expected 1", bus.echo_detected); end
    drive(1'b0, S_BIG, 1'b0);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL reemit_missed: got %0d pending echoes, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    bus.threshold_in = 11'd500;
    drive(1'b1, S_BIG, 1'b0);
    repeat (BLANK) drive(1'b0, S_BIG, 1'b0);
    repeat (3) drive(1'b0, S_BIG, 1'b1);
    rst_in = 1'b0;
    drive(1'b0, S_BIG, 1'b1);
    rst_in = 1'b1;
    tests++; if (bus.time_since_emission !== 32'd0 || bus.listening_out !== 1'b0 || bus.echo_detected !== 1'b0) begin fails++; $display("FAIL rstmid_outputs: got tse=%0d listen=%b echo=%b, expected 0/0/0", bus.time_since_emission, bus.listening_out, bus.echo_detected); end
    drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.echo_detected !== 1'b0 || bus.time_since_emission !== 32'd0) begin fails++; $display("FAIL rstmid_no_pulse: got echo=%b tse=%0d, expected 0/0", bus.echo_detected, bus.time_since_emission); end
    drive(1'b1, S_BIG, 1'b0);
    exp_q.push_back(BLANK + CONF);
    repeat (BLANK + CONF) drive(1'b0, S_BIG, 1'b1);
    tests++; if (bus.echo_detected !== 1'b1) begin fails++; $display("FAIL rstmid_clean_echo: got %b, expected 1", bus.echo_detected); end
    drive(1'b0, S_BIG, 1'b0);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rstmid_missed: got %0d pending echoes, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_saturation();
    bus.threshold_in = 11'd2047;
    drive(1'b1, S_BIG, 1'b0);
    repeat (BLANK) drive(1'b0, S_BIG, 1'b0);
    drive(1'b0, 12'd4094, 1'b1);  // amplitude 2046, just below
    exp_q.push_back(BLANK + 1 + CONF);
    drive(1'b0, 12'd0, 1'b1);     // 2048 clamps to 2047
    drive(1'b0, 12'd4095, 1'b1);
    drive(1'b0, 12'd0, 1'b1);
    drive(1'b0, 12'd1, 1'b1);
    tests++; if (bus.echo_detected !== 1'b1 || bus.time_since_emission !== 32'(BLANK + 1 + CONF)) begin fails++; $display("FAIL sat_echo: got echo=%b tse=%0d, expected 1/%0d", bus.echo_detected, bus.time_since_emission, BLANK + 1 + CONF); end
    drive(1'b0, S_BIG, 1'b0);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL sat_missed: got %0d pending echoes, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    bus.emit_start_in   = 1'b0;
    bus.sample_in       = '0;
    bus.sample_valid_in = 1'b0;
    bus.threshold_in    = '0;
    test_reset();
    test_basic();
    test_timeout();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
